// File: rtl/rvfi_check_sequencer_pkg.sv
// Shared types for the RVFI check sequencer.
// FSM state encoding and channel-index width helper.
package rvfi_seq_pkg;

  typedef enum logic [1:0] {
    S_HOLD,
    S_WARM,
    S_ARMED,
    S_DONE
  } seq_state_e;

  function automatic int idx_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rvfi_rr_pick.sv
// Combinational round-robin picker.
// Returns the first request at or above ptr, wrapping.
module rvfi_rr_pick
  import rvfi_seq_pkg::*;
#(
  parameter  int N  = 1,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [IW:0] w_sum;

  // scan downward so the smallest offset from ptr wins
  always_comb begin
    any   = 1'b0;
    idx   = '0;
    w_sum = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N))
        w_sum = w_sum - (IW+1)'(N);
      if (req[w_sum[IW-1:0]]) begin
        any = 1'b1;
        idx = w_sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/rvfi_check_sequencer.sv
// Single-shot check sequencer for RVFI channels.
// Holds core reset, warms up, then fires one check.
module rvfi_check_sequencer
  import rvfi_seq_pkg::*;
#(
  parameter  int NRET         = 1,
  parameter  int RESET_CYCLES = 1,
  parameter  int CHECK_CYCLE  = 10,
  parameter  int WINDOW       = 4,
  localparam int IW           = idx_w(NRET)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NRET-1:0] rvfi_valid,
  input  logic [NRET-1:0] rvfi_trap,
  output logic            core_reset,
  output logic            check,
  output logic [IW-1:0]   check_idx,
  output logic            fired,
  output logic            timeout,
  output logic            busy
);

  localparam int MX1 =
    (RESET_CYCLES > CHECK_CYCLE) ?
    RESET_CYCLES : CHECK_CYCLE;
  localparam int MX =
    (MX1 > WINDOW) ? MX1 : WINDOW;
  localparam int CW = $clog2(MX + 1);

  localparam logic [CW-1:0] RC_LAST =
    CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] CC_LAST =
    CW'((CHECK_CYCLE > 0) ? CHECK_CYCLE - 1 : 0);
  localparam logic [CW-1:0] WN_LAST =
    CW'(WINDOW - 1);

  seq_state_e    r_state;
  seq_state_e    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_ptr_nxt;
  logic          r_core_reset;
  logic          r_fired;
  logic          r_timeout;
  logic          w_fire;
  logic          w_to_set;
  logic          w_any;
  logic [IW-1:0] w_idx;
  logic          w_unused_trap;

  // trap is a checker-side concern only
  assign w_unused_trap = ^rvfi_trap;

  rvfi_rr_pick #(
    .N (NRET)
  ) u_pick (
    .req (rvfi_valid),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  // next-state, counter and pointer logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_fire      = 1'b0;
    w_to_set    = 1'b0;
    unique case (r_state)
      S_HOLD: begin
        if (r_cnt == RC_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (CHECK_CYCLE == 0) ?
                        S_ARMED : S_WARM;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_WARM: begin
        if (r_cnt == CC_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_ARMED;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_ARMED: begin
        if (w_any) begin
          w_fire      = 1'b1;
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
          w_ptr_nxt   = (w_idx == IW'(NRET - 1)) ?
                        '0 : w_idx + IW'(1);
        end else if (r_cnt == WN_LAST) begin
          w_to_set    = 1'b1;
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_HOLD;
      end
    endcase
  end

  // state, counter, pointer and sticky flags
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_HOLD;
      r_cnt        <= '0;
      r_ptr        <= '0;
      r_core_reset <= 1'b1;
      r_fired      <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_ptr        <= w_ptr_nxt;
      r_core_reset <= (w_state_nxt == S_HOLD);
      if (w_fire)
        r_fired <= 1'b1;
      if (w_to_set)
        r_timeout <= 1'b1;
    end
  end

  assign check = (r_state == S_ARMED) &
                 w_any & ~reset;
  assign check_idx  = check ? w_idx : '0;
  assign busy       = (r_state != S_DONE);
  assign core_reset = r_core_reset;
  assign fired      = r_fired;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// Bench for rvfi_check_sequencer.
// Picker vector table plus per-cycle scoreboard runs.
module tb_rvfi_check_sequencer;

  localparam int NRET = 4;
  localparam int RC   = 2;
  localparam int CC   = 3;
  localparam int WIN  = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rvfi_valid = '0;
  logic [3:0] rvfi_trap  = '0;
  logic       core_reset;
  logic       check;
  logic [1:0] check_idx;
  logic       fired;
  logic       timeout;
  logic       busy;

  logic [3:0] p_req = '0;
  logic [1:0] p_ptr = '0;
  logic       p_any;
  logic [1:0] p_idx;

  always #5 clock = ~clock;

  rvfi_check_sequencer #(
    .NRET         (NRET),
    .RESET_CYCLES (RC),
    .CHECK_CYCLE  (CC),
    .WINDOW       (WIN)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rvfi_valid (rvfi_valid),
    .rvfi_trap  (rvfi_trap),
    .core_reset (core_reset),
    .check      (check),
    .check_idx  (check_idx),
    .fired      (fired),
    .timeout    (timeout),
    .busy       (busy)
  );

  rvfi_rr_pick #(
    .N (4)
  ) u_pick (
    .req (p_req),
    .ptr (p_ptr),
    .any (p_any),
    .idx (p_idx)
  );

  typedef struct {
    logic [3:0] req;
    logic [1:0] ptr;
    logic       any;
    logic [1:0] idx;
  } pick_vec_t;

  typedef struct {
    logic       core_reset;
    logic       check;
    logic [1:0] idx;
    logic       fired;
    logic       timeout;
    logic       busy;
    int         cyc;
  } exp_t;

  pick_vec_t pv[9];
  exp_t      sbq[$];

  int checks   = 0;
  int failures = 0;

  int m_c;
  bit m_done;
  bit m_fired;
  bit m_to;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    rvfi_valid = '0;
    rvfi_trap  = '0;
    @(posedge clock);
    #1;
    reset   = 1'b0;
    m_c     = 0;
    m_done  = 1'b0;
    m_fired = 1'b0;
    m_to    = 1'b0;
  endtask

  task automatic run(input string tag,
                     input int ncyc,
                     input int vfrom,
                     input int vto,
                     input logic [3:0] vm,
                     input logic [3:0] tm,
                     input int rst_at);
    for (int i = 0; i < ncyc; i++) begin
      exp_t e;
      exp_t g;
      logic [3:0] v;
      bit r;
      v = (i >= vfrom && i <= vto) ? vm : 4'b0;
      r = (i == rst_at);
      rvfi_valid = v;
      rvfi_trap  = tm;
      reset      = r;
      e.core_reset = (m_c < RC);
      e.busy       = !m_done;
      e.fired      = m_fired;
      e.timeout    = m_to;
      e.check      = 1'b0;
      e.idx        = 2'd0;
      e.cyc        = i;
      if (r) begin
        m_c     = 0;
        m_done  = 1'b0;
        m_fired = 1'b0;
        m_to    = 1'b0;
      end else begin
        if (!m_done && m_c >= RC + CC) begin
          if (v != 4'b0) begin
            e.check = 1'b1;
            for (int k = 3; k >= 0; k--)
              if (v[k]) e.idx = 2'(k);
            m_done  = 1'b1;
            m_fired = 1'b1;
          end else if (m_c - (RC + CC) == WIN - 1) begin
            m_done = 1'b1;
            m_to   = 1'b1;
          end
        end
        m_c++;
      end
      sbq.push_back(e);
      @(negedge clock);
      if (sbq.size() == 0) begin
        chk({tag, " sb_empty"}, 32'd0, 32'd1);
      end else begin
        g = sbq.pop_front();
        chk($sformatf("%s c%0d core_reset", tag, g.cyc),
            32'(core_reset), 32'(g.core_reset));
        chk($sformatf("%s c%0d check", tag, g.cyc),
            32'(check), 32'(g.check));
        chk($sformatf("%s c%0d check_idx", tag, g.cyc),
            32'(check_idx), 32'(g.idx));
        chk($sformatf("%s c%0d fired", tag, g.cyc),
            32'(fired), 32'(g.fired));
        chk($sformatf("%s c%0d timeout", tag, g.cyc),
            32'(timeout), 32'(g.timeout));
        chk($sformatf("%s c%0d busy", tag, g.cyc),
            32'(busy), 32'(g.busy));
      end
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    pv[0] = '{4'b0000, 2'd0, 1'b0, 2'd0};
    pv[1] = '{4'b0001, 2'd0, 1'b1, 2'd0};
    pv[2] = '{4'b1010, 2'd0, 1'b1, 2'd1};
    pv[3] = '{4'b1010, 2'd2, 1'b1, 2'd3};
    pv[4] = '{4'b1010, 2'd3, 1'b1, 2'd3};
    pv[5] = '{4'b0011, 2'd2, 1'b1, 2'd0};
    pv[6] = '{4'b0100, 2'd3, 1'b1, 2'd2};
    pv[7] = '{4'b1111, 2'd1, 1'b1, 2'd1};
    pv[8] = '{4'b1000, 2'd0, 1'b1, 2'd3};

    for (int i = 0; i < 9; i++) begin
      p_req = pv[i].req;
      p_ptr = pv[i].ptr;
      #1;
      chk($sformatf("pick%0d any", i),
          32'(p_any), 32'(pv[i].any));
      if (pv[i].any)
        chk($sformatf("pick%0d idx", i),
            32'(p_idx), 32'(pv[i].idx));
    end

    do_reset();
    run("early_valid", 12, 0, 99, 4'b0001, 4'b0000, -1);
    do_reset();
    run("no_valid", 12, 0, -1, 4'b0000, 4'b0000, -1);
    do_reset();
    run("rr_a", 10, 5, 99, 4'b1010, 4'b0000, -1);
    do_reset();
    run("rr_b", 10, 5, 99, 4'b1010, 4'b0000, -1);
    do_reset();
    run("trap", 10, 0, 99, 4'b0100, 4'b0100, -1);
    do_reset();
    run("last_win", 12, 8, 8, 4'b1000, 4'b0000, -1);
    do_reset();
    run("mid_rst", 20, 0, 99, 4'b0001, 4'b0000, 5);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
